// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment driver. BCD digits are captured into a shadow buffer
// and copied to the display buffer only at a frame boundary, so a frame never shows mixed data.
module seven_seg_scan #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] ten_0,
  input  logic [3:0] ten_1,
  input  logic [3:0] ten_2,
  input  logic [3:0] ten_3,
  input  logic       load,
  input  logic       blank_zeros,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int            TW         = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES);

  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0][3:0] disp_q, disp_d;
  logic            pending_q, pending_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic       slot_end;
  logic       boundary;
  logic [3:0] cur_digit;
  logic       lead_zero;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end  = (tick_q == TICK_LAST);
    boundary  = slot_end && (idx_q == 2'd3);
    tick_d    = slot_end ? '0 : tick_q + 1'b1;
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
    shadow_d  = load ? {ten_3, ten_2, ten_1, ten_0} : shadow_q;
    // The boundary copy sees the shadow as it was before any same-cycle load.
    disp_d    = (boundary && pending_q) ? shadow_q : disp_q;
    pending_d = load | (pending_q & ~boundary);

    cur_digit = disp_q[idx_q];
    lead_zero = 1'b0;
    case (idx_q)
      2'd3:    lead_zero = (disp_q[3] == 4'd0);
      2'd2:    lead_zero = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0);
      2'd1:    lead_zero = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0) && (disp_q[1] == 4'd0);
      default: lead_zero = 1'b0;
    endcase

    an_d  = (tick_q < BLANK_LAST) ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = (blank_zeros && lead_zero) ? 7'h7F : encode(cur_digit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_q    <= '0;
      idx_q     <= 2'd0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
    end else begin
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = boundary;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with a per-frame scoreboard of expected an/seg/frame_done,
// built from a reference model of the shadow/display buffers.
module tb_seven_seg_scan;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ten_0 = '0, ten_1 = '0, ten_2 = '0, ten_3 = '0;
  logic       load = 1'b0;
  logic       blank_zeros = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  seven_seg_scan #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .ten_0(ten_0), .ten_1(ten_1), .ten_2(ten_2), .ten_3(ten_3),
    .load(load), .blank_zeros(blank_zeros),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_disp[4];
  logic [3:0] m_shadow[4];
  logic       m_pend;
  int         n_assert = 0;
  int         n_fail   = 0;

  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [6:0] table_v[16];
    table_v = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return table_v[d];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_disp[k]   = 4'd0;
      m_shadow[k] = 4'd0;
    end
    m_pend = 1'b0;
  endtask

  // One entry per scan state s = 0..31 of the coming frame.
  task automatic push_frame();
    for (int s = 0; s < 32; s++) begin
      int   j;
      int   t;
      logic hi_zero;
      exp_t e;
      j = s / 8;
      t = s % 8;
      hi_zero = 1'b1;
      for (int k = 3; k >= j; k--) if (m_disp[k] != 4'd0) hi_zero = 1'b0;
      e.an  = (t < 2) ? 4'hF : ~(4'b0001 << j);
      e.seg = (blank_zeros && j != 0 && hi_zero) ? 7'h7F : ref_enc(m_disp[j]);
      e.fd  = (s == 30);
      sb.push_back(e);
    end
  endtask

  // Starts with state 0 of a frame loaded; each iteration checks outputs for state m-1.
  task automatic run_frame(input int n, input int load_at,
                           input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
    exp_t e;
    push_frame();
    for (int m = 1; m <= n; m++) begin
      if (m == load_at) begin
        load = 1'b1;
        ten_3 = d3; ten_2 = d2; ten_1 = d1; ten_0 = d0;
      end
      @(posedge clock);
      @(negedge clock);
      load = 1'b0;
      e = sb.pop_front();
      chk($sformatf("an m=%0d", m), {4'b0, an}, {4'b0, e.an});
      chk($sformatf("seg m=%0d", m), {1'b0, seg}, {1'b0, e.seg});
      chk($sformatf("frame_done m=%0d", m), {7'b0, frame_done}, {7'b0, e.fd});
    end
    if (load_at >= 1 && load_at <= 31 && load_at <= n) begin
      m_shadow[3] = d3; m_shadow[2] = d2; m_shadow[1] = d1; m_shadow[0] = d0;
      m_pend = 1'b1;
    end
    if (n == 32) begin
      if (m_pend) for (int k = 0; k < 4; k++) m_disp[k] = m_shadow[k];
      m_pend = 1'b0;
      if (load_at == 32) begin
        m_shadow[3] = d3; m_shadow[2] = d2; m_shadow[1] = d1; m_shadow[0] = d0;
        m_pend = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset an", {4'b0, an}, 8'h0F);
    chk("reset seg", {1'b0, seg}, 8'h7F);
    chk("reset frame_done", {7'b0, frame_done}, 8'h00);
    reset = 1'b0;

    // Load mid-frame: this frame still shows zeros, the next shows 1,2,3,4.
    blank_zeros = 1'b0;
    run_frame(32, 3, 4'd1, 4'd2, 4'd3, 4'd4);
    run_frame(32, 5, 4'd0, 4'd0, 4'd7, 4'd0);
    // 0,0,7,0 with and without leading-zero blanking.
    blank_zeros = 1'b1;
    run_frame(32, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    blank_zeros = 1'b0;
    run_frame(32, 10, 4'd0, 4'd0, 4'd0, 4'd0);
    // All zeros blanked except digit 0, then a dash code in digit 2.
    blank_zeros = 1'b1;
    run_frame(32, 1, 4'd0, 4'd12, 4'd0, 4'd0);
    // Load on the boundary cycle: old value for one more frame, pending stays set.
    run_frame(32, 32, 4'd9, 4'd9, 4'd9, 4'd9);
    chk("pending after boundary load", {7'b0, dut.pending_q}, {7'b0, m_pend});
    run_frame(32, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("pending cleared", {7'b0, dut.pending_q}, {7'b0, m_pend});
    run_frame(32, 0, 4'd0, 4'd0, 4'd0, 4'd0);

    // Asynchronous reset during the digit 2 slot.
    run_frame(20, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    sb.delete();
    reset = 1'b1;
    #1;
    chk("async reset an", {4'b0, an}, 8'h0F);
    chk("async reset seg", {1'b0, seg}, 8'h7F);
    chk("async reset frame_done", {7'b0, frame_done}, 8'h00);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    blank_zeros = 1'b0;
    run_frame(32, 0, 4'd0, 4'd0, 4'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
